// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, data-memory wait
// handling with a timeout that halts the pipeline, plus stall/flush counters.
module hazard_control_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  ID_ADDR1,
   input  logic [4:0]  ID_ADDR2,
   input  logic        ID_USES_OP1,
   input  logic        ID_USES_OP2,
   input  logic [4:0]  EX_ADDR,
   input  logic        EX_WRITE_EN,
   input  logic        EX_MEM_READ,
   input  logic        BRANCH_TAKEN,
   input  logic        DMEM_BUSY,
   output logic        PC_HOLD,
   output logic        IFID_HOLD,
   output logic        IDEX_HOLD,
   output logic        EXMEM_HOLD,
   output logic        IFID_FLUSH,
   output logic        IDEX_BUBBLE,
   output logic        MEMWB_BUBBLE,
   output logic        MEM_TIMEOUT,
   output logic [15:0] STALL_COUNT,
   output logic [15:0] FLUSH_COUNT
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_HALT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic [15:0]   stall_cnt_q, stall_cnt_d;
   logic [15:0]   flush_cnt_q, flush_cnt_d;
   logic          mem_timeout_q, mem_timeout_d;

   logic load_use;
   logic pc_hold, ifid_hold, idex_hold, exmem_hold;
   logic ifid_flush, idex_bubble, memwb_bubble;

   // An operand only matters when the ID instruction actually reads it; x0 never stalls.
   assign load_use = EX_MEM_READ && EX_WRITE_EN && (EX_ADDR != '0) &&
                     ((ID_USES_OP1 && (ID_ADDR1 == EX_ADDR)) ||
                      (ID_USES_OP2 && (ID_ADDR2 == EX_ADDR)));

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_RUN: begin
            wait_cnt_d = '0;
            if (DMEM_BUSY) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!DMEM_BUSY) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Busy defers branch and load-use: EX is frozen and presents them again.
   always_comb begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      idex_hold    = 1'b0;
      exmem_hold   = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      memwb_bubble = 1'b0;
      if (RESET) begin
         pc_hold = 1'b0;
      end else if ((state_q == ST_HALT) || DMEM_BUSY) begin
         pc_hold      = 1'b1;
         ifid_hold    = 1'b1;
         idex_hold    = 1'b1;
         exmem_hold   = 1'b1;
         memwb_bubble = 1'b1;
      end else if (BRANCH_TAKEN) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_hold && (state_q != ST_HALT) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + 16'd1;
      mem_timeout_d = (state_d == ST_HALT);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign PC_HOLD      = pc_hold;
   assign IFID_HOLD    = ifid_hold;
   assign IDEX_HOLD    = idex_hold;
   assign EXMEM_HOLD   = exmem_hold;
   assign IFID_FLUSH   = ifid_flush;
   assign IDEX_BUBBLE  = idex_bubble;
   assign MEMWB_BUBBLE = memwb_bubble;
   assign MEM_TIMEOUT  = mem_timeout_q;
   assign STALL_COUNT  = stall_cnt_q;
   assign FLUSH_COUNT  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboarded bench for hazard_control_unit with a short memory timeout.
module tb_hazard_control_unit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [4:0]  ID_ADDR1 = '0, ID_ADDR2 = '0, EX_ADDR = '0;
   logic        ID_USES_OP1 = 1'b0, ID_USES_OP2 = 1'b0;
   logic        EX_WRITE_EN = 1'b0, EX_MEM_READ = 1'b0;
   logic        BRANCH_TAKEN = 1'b0, DMEM_BUSY = 1'b0;
   logic        PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD;
   logic        IFID_FLUSH, IDEX_BUBBLE, MEMWB_BUBBLE, MEM_TIMEOUT;
   logic [15:0] STALL_COUNT, FLUSH_COUNT;

   // ctrl order: PC_HOLD IFID_HOLD IDEX_HOLD EXMEM_HOLD IFID_FLUSH IDEX_BUBBLE MEMWB_BUBBLE
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LU   = 7'b1100010;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_HOLD = 7'b1111001;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [15:0] exp_stall = '0;
   logic [15:0] exp_flush = '0;
   logic        exp_tmo = 1'b0;
   logic [39:0] sb[$];
   string       names[$];
   logic [39:0] exp_v;
   string       nm;

   hazard_control_unit #(.TIMEOUT_CYCLES(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .ID_ADDR1(ID_ADDR1), .ID_ADDR2(ID_ADDR2),
      .ID_USES_OP1(ID_USES_OP1), .ID_USES_OP2(ID_USES_OP2),
      .EX_ADDR(EX_ADDR), .EX_WRITE_EN(EX_WRITE_EN), .EX_MEM_READ(EX_MEM_READ),
      .BRANCH_TAKEN(BRANCH_TAKEN), .DMEM_BUSY(DMEM_BUSY),
      .PC_HOLD(PC_HOLD), .IFID_HOLD(IFID_HOLD), .IDEX_HOLD(IDEX_HOLD),
      .EXMEM_HOLD(EXMEM_HOLD), .IFID_FLUSH(IFID_FLUSH), .IDEX_BUBBLE(IDEX_BUBBLE),
      .MEMWB_BUBBLE(MEMWB_BUBBLE), .MEM_TIMEOUT(MEM_TIMEOUT),
      .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [39:0] obs();
      return {PC_HOLD, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD, IFID_FLUSH, IDEX_BUBBLE,
              MEMWB_BUBBLE, STALL_COUNT, FLUSH_COUNT, MEM_TIMEOUT};
   endfunction

   // Drives one cycle of inputs and queues the outputs expected for it; then
   // advances the counter model to what the coming edge should produce.
   task automatic drive(input string name, input logic rst, busy, br, mr, we,
                        input logic [4:0] exa, a1, a2, input logic u1, u2,
                        input logic [6:0] ctrl);
      @(negedge CLK);
      RESET = rst; DMEM_BUSY = busy; BRANCH_TAKEN = br;
      EX_MEM_READ = mr; EX_WRITE_EN = we; EX_ADDR = exa;
      ID_ADDR1 = a1; ID_ADDR2 = a2; ID_USES_OP1 = u1; ID_USES_OP2 = u2;
      sb.push_back({ctrl, exp_stall, exp_flush, exp_tmo});
      names.push_back(name);
      if (rst) begin
         exp_stall = '0; exp_flush = '0; exp_tmo = 1'b0;
      end else begin
         if (ctrl[6] && !exp_tmo && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
         if (ctrl[2] && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
      end
   endtask

   task automatic idle(input string name);
      drive(name, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         if (i < 2)
            drive("reset_hold", 1, 1'($urandom), 1'($urandom), 1, 1, 5'd11, 5'd11,
                  5'd11, 1, 1, C_NONE);
         else
            idle("reset_release");
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
         end
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: drive("lu_op1", 0, 0, 0, 1, 1, 5'b01011, 5'b01011, 5'd3, 1, 0, C_LU);
            1: drive("lu_op2", 0, 0, 0, 1, 1, 5'd7, 5'd2, 5'd7, 0, 1, C_LU);
            default: idle("lu_after");
         endcase
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
         end
      end
   endtask

   task automatic test_no_stall();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive("ns_op1_unused", 0, 0, 0, 1, 1, 5'd11, 5'd11, 5'd0, 0, 0, C_NONE);
            1: drive("ns_x0", 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, C_NONE);
            2: drive("ns_not_load", 0, 0, 0, 0, 1, 5'd11, 5'd11, 5'd11, 1, 1, C_NONE);
            3: drive("ns_no_write", 0, 0, 0, 1, 0, 5'd11, 5'd11, 5'd11, 1, 1, C_NONE);
            default: drive("ns_op2_unused", 0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9, 1, 0, C_NONE);
         endcase
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
         end
      end
   endtask

   task automatic test_branch();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0: drive("br_over_lu", 0, 0, 1, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_BR);
            1: drive("br_plain", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_BR);
            default: idle("br_after");
         endcase
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
         end
      end
   endtask

   task automatic test_busy_branch();
      for (int i = 0; i < 6; i++) begin
         if (i < 3)
            drive("busy_br", 0, 1, 1, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_HOLD);
         else if (i == 3)
            drive("busy_drop_br", 0, 0, 1, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_BR);
         else if (i == 4)
            drive("busy_drop_lu", 0, 0, 0, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_LU);
         else
            idle("busy_after");
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
         end
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 25; i++) begin
         case (i)
            // four busy cycles stop one short of the timeout
            0, 1, 2, 3: drive("tmo_short_busy", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_HOLD);
            4, 5: idle("tmo_short_idle");
            6, 7, 8, 9, 10: begin
               drive("tmo_busy", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_HOLD);
               if (i == 10) exp_tmo = 1'b1;
            end
            11: drive("halt_br", 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_HOLD);
            12: drive("halt_lu", 0, 0, 0, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_HOLD);
            13: idle_halt();
            14: drive("halt_reset", 1, 1, 1, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_NONE);
            15: idle("post_halt_reset");
            16, 17: drive("wait_busy", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_HOLD);
            18: drive("wait_reset", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE);
            19, 20, 21, 22: drive("post_wait_busy", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_HOLD);
            default: idle("post_wait_idle");
         endcase
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
         if (obs() !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
         end
      end
   endtask

   task automatic idle_halt();
      drive("halt_idle", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_HOLD);
   endtask

   task automatic test_saturation();
      drive("sat_reset", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, C_NONE);
      #1;
      exp_v = sb.pop_front(); nm = names.pop_front(); checks++;
      if (obs() !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, obs(), exp_v);
      end
      for (int i = 0; i < 65541; i++) begin
         if (i < 65540)
            drive("sat_lu", 0, 0, 0, 1, 1, 5'd11, 5'd11, 5'd0, 1, 0, C_LU);
         else
            idle("sat_idle");
         #1;
         exp_v = sb.pop_front(); nm = names.pop_front();
         if (i < 2 || i > 65532) begin
            checks++;
            if (obs() !== exp_v) begin
               errors++;
               $display("FAIL %s[%0d]: got %h expected %h", nm, i, obs(), exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_busy_branch();
      test_timeout();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
